rns2bin_32_31_21_5: RTL and testbench

Reverse converter for the RNS moduli set (32, 31, 21, 5): accepts a residue tuple from the RNS datapath, as produced by the forward binary-to-RNS stage, and reconstructs the 17-bit binary integer. It uses iterative mixed-radix conversion (MRC) under a 4-state compute FSM. It sits directly downstream of the RNS arithmetic/forward-conversion stages, with valid/ready handshakes on both sides.

---
 rtl/rns_32_31_21_5_pkg.sv | 22 ++
 rtl/rns_mod_reduce_small.sv | 19 +
 rtl/rns2bin_32_31_21_5.sv | 105 ++++++++++
 tb/tb_rns2bin_32_31_21_5.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rns_32_31_21_5_pkg.sv
// rns_32_31_21_5_pkg: shared constants and types for the (32, 31, 21, 5) RNS converters.
// Contents: moduli, residue widths, MRC inverses and weights, dynamic range, FSM state enum.
package rns_32_31_21_5_pkg;
   localparam int MOD_1 = 32;
   localparam int MOD_2 = 31;
   localparam int MOD_3 = 21;
   localparam int MOD_4 = 5;
   localparam int MOD_SIZE = 5;
   localparam int RES_W_1 = 5;
   localparam int RES_W_2 = 5;
   localparam int RES_W_3 = 5;
   localparam int RES_W_4 = 3;
   localparam int INV_11_MOD_21 = 2;
   localparam int INV_10_MOD_21 = 19;
   localparam int INV_2_MOD_5 = 3;
   localparam int WEIGHT_2 = 32;
   localparam int WEIGHT_3 = 992;
   localparam int WEIGHT_4 = 20832;
   localparam int DYN_SIZE = 17;
   localparam int DYN_RANGE = 104160;
   typedef enum logic [2:0] {IDLE, S_V2, S_V3, S_V4, S_SUM, S_OUT} state_t;
endpackage

// File: rtl/rns_mod_reduce_small.sv
// rns_mod_reduce_small: combinational x mod M by a fixed chain of conditional subtractions.
// Ports: x (W-bit unsigned operand), y (x mod M, $clog2(M) bits).
module rns_mod_reduce_small #(
   parameter int M = 31,
   parameter int W = 7
) (
   input  logic [W-1:0]           x,
   output logic [$clog2(M)-1:0]   y
);
   localparam int OW = $clog2(M);
   // enough steps to bring the largest W-bit value below M
   localparam int STEPS = ((1 << W) - 1) / M;
   logic [W-1:0] t;
   always_comb begin
      t = x;
      for (int i = 0; i < STEPS; i++) t = (t >= W'(M)) ? t - W'(M) : t;
   end
   assign y = OW'(t);
endmodule

// File: rtl/rns2bin_32_31_21_5.sv
// rns2bin_32_31_21_5: mixed-radix reverse converter, residues (32,31,21,5) -> 17-bit binary.
// Ports: clk, reset (async, active-high); in_valid/in_ready with in_mod_1..4 residues;
//        out_valid/out_ready with out_bin (reconstructed X) and out_err (residue out of range).
module rns2bin_32_31_21_5
   import rns_32_31_21_5_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MOD_SIZE-1:0] in_mod_1,
   input  logic [MOD_SIZE-1:0] in_mod_2,
   input  logic [MOD_SIZE-1:0] in_mod_3,
   input  logic [MOD_SIZE-1:0] in_mod_4,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DYN_SIZE-1:0] out_bin,
   output logic                out_err
);
   state_t state;
   // v1 doubles as the stored r1 residue
   logic [MOD_SIZE-1:0] r2, r3, r4, v1, v2, v3;
   logic [RES_W_4-1:0] v4;
   logic err;
   logic [6:0] a2, a3, b3, a4, b4;
   logic [8:0] c3;
   logic [4:0] v2_n, t3, u3, v3_n;
   logic [2:0] t4, v4_n;
   logic [DYN_SIZE-1:0] sum;

   // each subtraction is offset by a multiple of the modulus so it never underflows
   assign a2 = 7'(r2) + 7'd62 - 7'(v1);
   rns_mod_reduce_small #(.M(MOD_2), .W(7)) u_v2 (.x(a2), .y(v2_n));

   assign a3 = 7'(r3) + 7'd42 - 7'(v1);
   rns_mod_reduce_small #(.M(MOD_3), .W(7)) u_a3 (.x(a3), .y(t3));
   assign b3 = 7'({t3, 1'b0}) + 7'd42 - 7'(v2);
   rns_mod_reduce_small #(.M(MOD_3), .W(7)) u_b3 (.x(b3), .y(u3));
   // times 19 = 16 + 2 + 1
   assign c3 = (9'(u3) << 4) + (9'(u3) << 1) + 9'(u3);
   rns_mod_reduce_small #(.M(MOD_3), .W(9)) u_c3 (.x(c3), .y(v3_n));

   assign a4 = 7'(r4) + 7'd35 - 7'(v1);
   rns_mod_reduce_small #(.M(MOD_4), .W(7)) u_a4 (.x(a4), .y(t4));
   // times 3, then subtract v2 and v3 with a +50 offset
   assign b4 = 7'(t4) + 7'({t4, 1'b0}) + 7'd50 - 7'(v2) - 7'(v3);
   rns_mod_reduce_small #(.M(MOD_4), .W(7)) u_b4 (.x(b4), .y(v4_n));

   // 992 = 1024 - 32, 20832 = 16384 + 4096 + 256 + 64 + 32
   assign sum = 17'(v1) + (17'(v2) << 5) + ((17'(v3) << 10) - (17'(v3) << 5))
              + (17'(v4) << 14) + (17'(v4) << 12) + (17'(v4) << 8) + (17'(v4) << 6) + (17'(v4) << 5);

   assign in_ready = state == IDLE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         r2        <= '0;
         r3        <= '0;
         r4        <= '0;
         v1        <= '0;
         v2        <= '0;
         v3        <= '0;
         v4        <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               v1    <= in_mod_1;
               r2    <= in_mod_2;
               r3    <= in_mod_3;
               r4    <= in_mod_4;
               err   <= (in_mod_2 >= 5'd31) || (in_mod_3 >= 5'd21) || (in_mod_4 >= 5'd5);
               state <= S_V2;
            end
            S_V2: begin
               v2    <= v2_n;
               state <= S_V3;
            end
            S_V3: begin
               v3    <= v3_n;
               state <= S_V4;
            end
            S_V4: begin
               v4    <= v4_n;
               state <= S_SUM;
            end
            S_SUM: begin
               out_bin   <= err ? '0 : sum;
               out_err   <= err;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rns2bin_32_31_21_5.sv
// tb_rns2bin_32_31_21_5: scoreboard bench for the (32,31,21,5) reverse converter.
module tb_rns2bin_32_31_21_5;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [4:0] in_mod_1 = '0, in_mod_2 = '0, in_mod_3 = '0, in_mod_4 = '0;
   logic out_valid;
   logic out_ready = 1'b1;
   logic [16:0] out_bin;
   logic out_err;
   logic [17:0] exp_q[$];
   int checks = 0;
   int passes = 0;
   bit rnd = 1'b0;

   rns2bin_32_31_21_5 dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_mod_1(in_mod_1), .in_mod_2(in_mod_2), .in_mod_3(in_mod_3), .in_mod_4(in_mod_4),
      .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_err(out_err)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endfunction

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_result: got bin=%0d err=%0d, required no result", out_bin, out_err);
         end else chk("result", 32'({out_err, out_bin}), 32'(exp_q.pop_front()));
      end
   end

   task automatic send(input int x1, input int x2, input int x3, input int x4,
                       input int eb, input bit ee, input bit push);
      int n = 0;
      while (!in_ready && n < 200) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_mod_1 = 5'(x1); in_mod_2 = 5'(x2); in_mod_3 = 5'(x3); in_mod_4 = 5'(x4);
      @(posedge clk);
      if (push) exp_q.push_back({ee, 17'(eb)});
      #1;
      in_valid = 1'b0;
      in_mod_1 = 5'($urandom); in_mod_2 = 5'($urandom); in_mod_3 = 5'($urandom); in_mod_4 = 5'($urandom);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int lat;
      int x;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({in_ready, out_valid, out_err, out_bin}), 32'({1'b1, 1'b0, 1'b0, 17'd0}));
      reset = 1'b0;
      @(posedge clk); #1;
      send(0, 0, 0, 0, 0, 0, 1);
      wait_valid(lat);
      chk("latency", 32'(lat), 32'd4);
      send(31, 1, 15, 0, 65535, 0, 1);
      send(31, 30, 20, 4, 104159, 0, 1);
      send(1, 1, 1, 1, 1, 0, 1);
      send(0, 1, 11, 2, 32, 0, 1);
      send(8, 8, 13, 0, 1000, 0, 1);
      send(0, 0, 0, 2, 20832, 0, 1);
      send(25, 7, 18, 0, 12345, 0, 1);
      send(31, 24, 18, 4, 99999, 0, 1);
      send(0, 31, 0, 0, 0, 1, 1);
      send(5, 3, 21, 1, 0, 1, 1);
      send(9, 3, 2, 5, 0, 1, 1);
      drain();
      out_ready = 1'b0;
      send(25, 7, 18, 0, 12345, 0, 1);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_hold", 32'({in_ready, out_valid, out_err, out_bin}), 32'({1'b0, 1'b1, 1'b0, 17'd12345}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 32'({in_ready, out_valid}), 32'b10);
      chk("bp_queue", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b0;
      send(1, 1, 1, 1, 1, 0, 0);
      wait_valid(lat);
      reset = 1'b1;
      #1;
      chk("reset_async_out", 32'({in_ready, out_valid, out_err, out_bin}), 32'({1'b1, 1'b0, 1'b0, 17'd0}));
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      send(2, 2, 2, 2, 2, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("reset_in_v3", 32'({in_ready, out_valid}), 32'b10);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);
      send(25, 7, 18, 0, 12345, 0, 1);
      drain();
      rnd = 1'b1;
      for (int i = 0; i < 300; i++) begin
         x = $urandom_range(0, 104159);
         send(x % 32, x % 31, x % 21, x % 5, x, 0, 1);
      end
      rnd = 1'b0;
      drain();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
